// File: rtl/synch_filt.sv
// synch_filt: multi-channel input synchroniser with per-channel debounce
// filter and registered rise/fall/changed pulses. Single clock domain,
// synchronous active-low reset.
module synch_filt #(
   parameter int unsigned     WIDTH     = 1,
   parameter int unsigned     STAGES    = 2,
   parameter int unsigned     FILTER    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] i,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam int unsigned CNT_W = (FILTER > 1) ? $clog2(FILTER) : 1;

   // Reject illegal parameterisations at elaboration
   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("synch_filt: STAGES must be in 2..4");
   end
   if (FILTER < 1 || FILTER > 65535) begin : g_bad_filter
      $error("synch_filt: FILTER must be in 1..65535");
   end

   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]             s_c;
   logic [WIDTH-1:0]             upd_c;
   logic [WIDTH-1:0]             o_q, o_d;
   logic [WIDTH-1:0]             rise_q, rise_d;
   logic [WIDTH-1:0]             fall_q, fall_d;
   logic                         changed_q, changed_d;

   // Synchroniser chain: stage 0 samples the async input
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= {STAGES{RESET_VAL}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], i};
      end
   end

   assign s_c = sync_q[STAGES-1];

   // Per-channel stability counter; a channel updates once its synchronised
   // value has differed from the output for FILTER consecutive edges
   for (genvar b = 0; b < WIDTH; b++) begin : g_ch
      if (FILTER > 1) begin : g_cnt
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             at_max_c;

         assign at_max_c = (cnt_q == CNT_W'(FILTER - 1));

         // Count mismatching edges; any match or an accepted change restarts
         always_comb begin
            cnt_d = cnt_q;
            if (s_c[b] == o_q[b]) begin
               cnt_d = '0;
            end else if (at_max_c) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         // Counter register, cleared by reset so pending debounce is dropped
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign upd_c[b] = (s_c[b] != o_q[b]) && at_max_c;
      end else begin : g_nocnt
         assign upd_c[b] = (s_c[b] != o_q[b]);
      end
   end

   // Next output value and edge pulses from the per-channel update strobes
   always_comb begin
      o_d       = (o_q & ~upd_c) | (s_c & upd_c);
      rise_d    = upd_c & s_c;
      fall_d    = upd_c & ~s_c;
      changed_d = |(rise_d | fall_d);
   end

   // Output and pulse registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         o_q       <= RESET_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
      end else begin
         o_q       <= o_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign o       = o_q;
   assign rise    = rise_q;
   assign fall    = fall_q;
   assign changed = changed_q;

endmodule
